ahb_2m1s_arbiter: RTL and testbench
===================================

Name: ahb_2m1s_arbiter

Overview:
- Pipelined AHB-Lite arbiter that shares one AHB-Lite slave port between two masters.
- Masters: M1 is the EL2 IFU port; M2 is the EL2 LSU port.
- Handles the AHB-Lite case where masters have no HGRANT. A master's address phase accepted while it does not own the slave is captured in a pending register, and that master is stalled until the captured transfer completes.
- Sits between el2_swerv_wrapper and the SoC AHB-Lite fabric inside the SoC wrapper.

Parameters:
- AW, 32, address width.
- DW, 64, data width.

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR_M1 / HADDR_M2  in  AW  master address.
- HTRANS_M1 / HTRANS_M2  in  2  master transfer type.
- HWRITE_M1 / HWRITE_M2  in  1  master write control.
- HSIZE_M1 / HSIZE_M2  in  3  master transfer size.
- HWDATA_M1 / HWDATA_M2  in  DW  master write data.
- HREADY_M1 / HREADY_M2  out  1  per-master ready.
- HRDATA_M1 / HRDATA_M2  out  DW  per-master read data (slave HRDATA broadcast to both).
- HADDR  out  AW  slave address.
- HTRANS  out  2  slave transfer type.
- HWRITE  out  1  slave write control.
- HSIZE  out  3  slave transfer size.
- HWDATA  out  DW  slave write data.
- HREADY  in  1  slave ready.
- HRDATA  in  DW  slave read data.

Behaviour:
- Clocking and reset: single clock HCLK; reset HRESETn is asynchronous, active-low.
- Reset state:
  - pend_v_M1 = pend_v_M2 = 0.
  - Data owner down = NONE.
  - Grant register gnt_q = NONE; lock_q = 0.
  - RR pointer favours M1.
- Outputs during and just after reset: HTRANS = 2'b00, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0, HREADY_M1 = HREADY_M2 = 1.
- Request of master x, req_x:
  - pend_v_x, or
  - live: HTRANS_x[1] = 1 and HREADY_x = 1.
  - BUSY and IDLE are never requests.
- Winner selection (combinational):
  - If lock_q = 1, winner = gnt_q.
  - Otherwise arbitrate between req_M1 and req_M2. Fixed priority is M1 > M2; see the optional feature for round-robin.
- Slave address phase:
  - Winner present: drive the winner's pending register if pend_v is set, else its live bus.
  - HTRANS is always forced to 2'b10 (NONSEQ); bursts are decomposed into single beats.
  - No winner: HTRANS = 2'b00, and HADDR/HWRITE/HSIZE = 0.
- Per-edge updates:
  - lock_q <= (winner != NONE) & !HREADY.
  - gnt_q <= winner.
  - If HREADY = 1: down <= winner; the winner's pend_v is cleared.
- Capture: at an edge where master x has a live request that is not (winner == x and HREADY = 1), latch {HADDR_x, HWRITE_x, HSIZE_x} and set pend_v_x.
- HREADY_x:
  - 0 while pend_v_x = 1.
  - HREADY when down == x.
  - 1 otherwise (IDLE gets a zero-wait OKAY).
- HWDATA = HWDATA of down; 0 when down = NONE.
  - The master holds HWDATA throughout its stall, so write data is never buffered.
- Latency:
  - A direct win adds 0 cycles.
  - A captured transfer adds at least 1 cycle plus any competing data phase.
- Boundary conditions:
  - Simultaneous live requests: the winner proceeds and the loser is captured in the same cycle.
  - A pending request and a live request never coexist for the same master.
  - Slave stall (HREADY = 0) with an active address phase: the address is held stable via lock_q. A master whose live request is "accepted" during the stall is captured, and the slave-side contents are unchanged.
  - Reset asserted mid-transfer: pending transfers are dropped and all outputs return asynchronously to their reset values.

Optional Feature:
- Macro: AHB_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-grant register updates on every edge where a winner exists and HREADY = 1.
  - On contention, the master that was not granted last wins; worst-case wait is one transfer.
- Undefined: fixed priority M1 > M2, and no last-grant register.

Decomposition:
- Package ahb_arb_pkg:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - Owner encoding NONE/M1/M2 (2 bits).
- One sub-module, ahb_arb_pend_reg, instantiated twice. It holds the per-master capture register: valid bit, AW address, write bit, 3-bit size, and the set/clear logic.

Test Plan:
- Reset pulse mid-transfer (M1 address phase active, HREADY = 0): all outputs go to reset values immediately; after release, HREADY_M1 = HREADY_M2 = 1 and HTRANS = 0.
- M1 only, NONSEQ read 0x100 then 0x108, zero-wait slave: HADDR shows 0x100 then 0x108 in consecutive cycles; HREADY_M1 stays 1; HRDATA_M1 = slave data.
- Both masters request in the same cycle (M1 read 0x200, M2 write 0x8000, data 0xDEAD_BEEF): M1 is granted and M2 captured with HREADY_M2 = 0. The next cycle drives HADDR = 0x8000, HWRITE = 1; HWDATA = 0xDEAD_BEEF in the following cycle, with HREADY_M2 = 1 then.
- Slave inserts 3 wait states on an M2 write while M1 issues a read: HADDR/HTRANS stay stable throughout; M1 is captured; M1's address is issued on the cycle HREADY returns.
- Without AHB_ARB_RR_EN, M1 requests continuously and M2 requests once: M2 remains pending (starved) while M1 requests.
- With AHB_ARB_RR_EN, the same stimulus: grants alternate M1, M2, M1, and the M2 transfer completes within 2 transfers.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the two-master AHB-Lite arbiter: transfer types, data/grant owner,
// and a helper that recognises an active transfer.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        OwnNone = 2'b00,
        OwnM1   = 2'b01,
        OwnM2   = 2'b10
    } owner_e;

    function automatic logic is_xfer(logic [1:0] htrans);
        return (htrans == HtransNonseq) || (htrans == HtransSeq);
    endfunction

endpackage

// File: rtl/ahb_2m1s_arbiter_if.sv
// One AHB-Lite link. The master modport issues transfers; the slave modport answers them.
interface ahb_2m1s_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
);
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic [DW-1:0] hrdata;

    modport master (
        output haddr, htrans, hwrite, hsize, hwdata,
        input  hready, hrdata
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hwdata,
        output hready, hrdata
    );
endinterface

// File: rtl/ahb_arb_pend_reg.sv
// Capture register for one master's address phase that could not be issued directly.
// Holds it until the arbiter issues it to the slave.
module ahb_arb_pend_reg #(
    parameter int unsigned AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          set_i,
    input  logic          clr_i,
    input  logic [AW-1:0] addr_i,
    input  logic          write_i,
    input  logic [2:0]    size_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic          write_o,
    output logic [2:0]    size_o
);
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        if (set_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            write_d = write_i;
            size_d  = size_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign write_o = write_q;
    assign size_o  = size_q;
endmodule

// File: rtl/ahb_2m1s_arbiter.sv
// Shares one AHB-Lite slave between the IFU (m1) and LSU (m2) ports without HGRANT: losers
// are captured and stalled. Define AHB_ARB_RR_EN for round-robin instead of fixed M1 > M2.
module ahb_2m1s_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
) (
    input logic                HCLK,
    input logic                HRESETn,
    ahb_2m1s_arbiter_if.slave  m1_io,
    ahb_2m1s_arbiter_if.slave  m2_io,
    ahb_2m1s_arbiter_if.master slv_io
);
    owner_e winner, contend_win;
    owner_e gnt_q, gnt_d, down_q, down_d;
    logic   lock_q, lock_d;

    logic          pend_v_m1, pend_w_m1, pend_v_m2, pend_w_m2;
    logic [AW-1:0] pend_a_m1, pend_a_m2;
    logic [2:0]    pend_s_m1, pend_s_m2;

    logic hready_m1, hready_m2, live_m1, live_m2, req_m1, req_m2;
    logic cap_m1, cap_m2, clr_m1, clr_m2;

    logic [AW-1:0] addr_sel;
    logic          write_sel;
    logic [2:0]    size_sel;
    logic [DW-1:0] wdata_sel;

    // A stalled master sees HREADY low; the data owner follows the slave; otherwise idle OKAY.
    always_comb begin
        hready_m1 = 1'b1;
        if (pend_v_m1) begin
            hready_m1 = 1'b0;
        end else if (down_q == OwnM1) begin
            hready_m1 = slv_io.hready;
        end
        hready_m2 = 1'b1;
        if (pend_v_m2) begin
            hready_m2 = 1'b0;
        end else if (down_q == OwnM2) begin
            hready_m2 = slv_io.hready;
        end
    end

    assign live_m1 = is_xfer(m1_io.htrans) & hready_m1;
    assign live_m2 = is_xfer(m2_io.htrans) & hready_m2;
    assign req_m1  = pend_v_m1 | live_m1;
    assign req_m2  = pend_v_m2 | live_m2;

`ifdef AHB_ARB_RR_EN
    logic prefer_m2_q, prefer_m2_d;

    always_comb begin
        prefer_m2_d = prefer_m2_q;
        if (slv_io.hready && (winner != OwnNone)) begin
            prefer_m2_d = (winner == OwnM1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prefer_m2_q <= 1'b0;
        end else begin
            prefer_m2_q <= prefer_m2_d;
        end
    end

    assign contend_win = prefer_m2_q ? OwnM2 : OwnM1;
`else
    assign contend_win = OwnM1;
`endif

    // Gated by reset so the slave side is idle immediately, even with masters still active.
    always_comb begin
        winner = OwnNone;
        if (HRESETn) begin
            if (lock_q) begin
                winner = gnt_q;
            end else if (req_m1 && req_m2) begin
                winner = contend_win;
            end else if (req_m1) begin
                winner = OwnM1;
            end else if (req_m2) begin
                winner = OwnM2;
            end
        end
    end

    always_comb begin
        addr_sel  = '0;
        write_sel = 1'b0;
        size_sel  = '0;
        unique case (winner)
            OwnM1: begin
                addr_sel  = pend_v_m1 ? pend_a_m1 : m1_io.haddr;
                write_sel = pend_v_m1 ? pend_w_m1 : m1_io.hwrite;
                size_sel  = pend_v_m1 ? pend_s_m1 : m1_io.hsize;
            end
            OwnM2: begin
                addr_sel  = pend_v_m2 ? pend_a_m2 : m2_io.haddr;
                write_sel = pend_v_m2 ? pend_w_m2 : m2_io.hwrite;
                size_sel  = pend_v_m2 ? pend_s_m2 : m2_io.hsize;
            end
            default: ;
        endcase
    end

    always_comb begin
        wdata_sel = '0;
        unique case (down_q)
            OwnM1:   wdata_sel = m1_io.hwdata;
            OwnM2:   wdata_sel = m2_io.hwdata;
            default: ;
        endcase
    end

    assign slv_io.htrans = (winner == OwnNone) ? HtransIdle : HtransNonseq;
    assign slv_io.haddr  = addr_sel;
    assign slv_io.hwrite = write_sel;
    assign slv_io.hsize  = size_sel;
    assign slv_io.hwdata = wdata_sel;

    assign m1_io.hready = hready_m1;
    assign m2_io.hready = hready_m2;
    assign m1_io.hrdata = slv_io.hrdata;
    assign m2_io.hrdata = slv_io.hrdata;

    // Any accepted request that is not issued to a ready slave this cycle gets captured.
    assign clr_m1 = (winner == OwnM1) & slv_io.hready;
    assign clr_m2 = (winner == OwnM2) & slv_io.hready;
    assign cap_m1 = live_m1 & ~clr_m1;
    assign cap_m2 = live_m2 & ~clr_m2;

    always_comb begin
        lock_d = (winner != OwnNone) && !slv_io.hready;
        gnt_d  = winner;
        down_d = slv_io.hready ? winner : down_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lock_q <= 1'b0;
            gnt_q  <= OwnNone;
            down_q <= OwnNone;
        end else begin
            lock_q <= lock_d;
            gnt_q  <= gnt_d;
            down_q <= down_d;
        end
    end

    ahb_arb_pend_reg #(.AW(AW)) u_pend_m1 (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .set_i   (cap_m1),
        .clr_i   (clr_m1),
        .addr_i  (m1_io.haddr),
        .write_i (m1_io.hwrite),
        .size_i  (m1_io.hsize),
        .valid_o (pend_v_m1),
        .addr_o  (pend_a_m1),
        .write_o (pend_w_m1),
        .size_o  (pend_s_m1)
    );

    ahb_arb_pend_reg #(.AW(AW)) u_pend_m2 (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .set_i   (cap_m2),
        .clr_i   (clr_m2),
        .addr_i  (m2_io.haddr),
        .write_i (m2_io.hwrite),
        .size_i  (m2_io.hsize),
        .valid_o (pend_v_m2),
        .addr_o  (pend_a_m2),
        .write_o (pend_w_m2),
        .size_o  (pend_s_m2)
    );
endmodule

// File: tb/tb_ahb_2m1s_arbiter.sv
// Bench for ahb_2m1s_arbiter: directed vector table, reset/starvation sequences, and random
// traffic against a behavioural model of the arbitration rules.
module tb_ahb_2m1s_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
`ifdef AHB_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_2m1s_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    ahb_2m1s_arbiter_if #(.AW(AW), .DW(DW)) m2_if ();
    ahb_2m1s_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

    ahb_2m1s_arbiter #(.AW(AW), .DW(DW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .m1_io   (m1_if),
        .m2_io   (m2_if),
        .slv_io  (s_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: masters indexed 0 (M1) and 1 (M2); -1 means no owner.
    int          m_down, m_gnt;
    bit          m_lock, m_pref_m2;
    bit          m_pv[2];
    logic [31:0] m_pa[2];
    bit          m_pw[2];
    logic [2:0]  m_ps[2];

    int          e_win;
    bit          e_hr[2];
    bit          e_live[2];
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    bit          e_hwrite;
    logic [2:0]  e_hsize;
    logic [63:0] e_hwdata;

    typedef struct {
        logic [1:0]  t1;
        logic [31:0] a1;
        bit          w1;
        logic [1:0]  t2;
        logic [31:0] a2;
        bit          w2;
        logic [63:0] wd2;
        bit          rdy;
        logic [63:0] rdata;
        logic [1:0]  x_trans;
        logic [31:0] x_addr;
        bit          x_write;
        logic [63:0] x_wdata;
        bit          x_hr1;
        bit          x_hr2;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_down = -1;
        m_gnt = -1;
        m_lock = 1'b0;
        m_pref_m2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pv[i] = 1'b0;
            m_pa[i] = '0;
            m_pw[i] = 1'b0;
            m_ps[i] = '0;
        end
    endtask

    task automatic model_eval();
        logic [1:0]  ht[2];
        logic [31:0] ad[2];
        bit          wr[2];
        logic [2:0]  sz[2];
        logic [63:0] wd[2];
        bit          req[2];
        ht[0] = m1_if.htrans; ad[0] = m1_if.haddr; wr[0] = m1_if.hwrite;
        sz[0] = m1_if.hsize;  wd[0] = m1_if.hwdata;
        ht[1] = m2_if.htrans; ad[1] = m2_if.haddr; wr[1] = m2_if.hwrite;
        sz[1] = m2_if.hsize;  wd[1] = m2_if.hwdata;
        for (int i = 0; i < 2; i++) begin
            e_hr[i] = m_pv[i] ? 1'b0 : ((m_down == i) ? s_if.hready : 1'b1);
            e_live[i] = ht[i][1] && e_hr[i];
            req[i] = m_pv[i] || e_live[i];
        end
        e_win = -1;
        if (HRESETn) begin
            if (m_lock) e_win = m_gnt;
            else if (req[0] && req[1]) e_win = (RrEn && m_pref_m2) ? 1 : 0;
            else if (req[0]) e_win = 0;
            else if (req[1]) e_win = 1;
        end
        e_htrans = (e_win >= 0) ? 2'b10 : 2'b00;
        e_haddr = '0;
        e_hwrite = 1'b0;
        e_hsize = '0;
        if (e_win >= 0) begin
            e_haddr  = m_pv[e_win] ? m_pa[e_win] : ad[e_win];
            e_hwrite = m_pv[e_win] ? m_pw[e_win] : wr[e_win];
            e_hsize  = m_pv[e_win] ? m_ps[e_win] : sz[e_win];
        end
        e_hwdata = (m_down >= 0) ? wd[m_down] : 64'h0;
    endtask

    task automatic model_step();
        bit cap[2];
        if (!HRESETn) return;
        for (int i = 0; i < 2; i++) cap[i] = e_live[i] && !(e_win == i && s_if.hready);
        m_lock = (e_win >= 0) && !s_if.hready;
        m_gnt = e_win;
        if (s_if.hready) begin
            m_down = e_win;
            if (e_win >= 0) begin
                m_pv[e_win] = 1'b0;
                m_pref_m2 = (e_win == 0);
            end
        end
        if (cap[0]) begin
            m_pv[0] = 1'b1; m_pa[0] = m1_if.haddr; m_pw[0] = m1_if.hwrite; m_ps[0] = m1_if.hsize;
        end
        if (cap[1]) begin
            m_pv[1] = 1'b1; m_pa[1] = m2_if.haddr; m_pw[1] = m2_if.hwrite; m_ps[1] = m2_if.hsize;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_htrans"}, 64'(s_if.htrans), 64'(e_htrans));
        chk({tag, "_haddr"}, 64'(s_if.haddr), 64'(e_haddr));
        chk({tag, "_hwrite"}, 64'(s_if.hwrite), 64'(e_hwrite));
        chk({tag, "_hsize"}, 64'(s_if.hsize), 64'(e_hsize));
        chk({tag, "_hwdata"}, s_if.hwdata, e_hwdata);
        chk({tag, "_hready_m1"}, 64'(m1_if.hready), 64'(e_hr[0]));
        chk({tag, "_hready_m2"}, 64'(m2_if.hready), 64'(e_hr[1]));
        chk({tag, "_hrdata_m1"}, m1_if.hrdata, s_if.hrdata);
        chk({tag, "_hrdata_m2"}, m2_if.hrdata, s_if.hrdata);
    endtask

    task automatic drive_m(input int i, input logic [1:0] t, input logic [31:0] a, input bit w,
                           input logic [2:0] sz, input logic [63:0] wd);
        if (i == 0) begin
            m1_if.htrans = t; m1_if.haddr = a; m1_if.hwrite = w;
            m1_if.hsize = sz; m1_if.hwdata = wd;
        end else begin
            m2_if.htrans = t; m2_if.haddr = a; m2_if.hwrite = w;
            m2_if.hsize = sz; m2_if.hwdata = wd;
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        model_step();
        #1;
    endtask

    initial begin
        int k;
        // t1 a1 w1 | t2 a2 w2 wd2 | rdy rdata || trans addr write wdata hr1 hr2
        vt[0]  = '{2'b10, 32'h100, 1'b0, 2'b00, 32'h0, 1'b0, 64'h0, 1'b1, 64'h0,
                   2'b10, 32'h100, 1'b0, 64'h0, 1'b1, 1'b1};
        vt[1]  = '{2'b10, 32'h108, 1'b0, 2'b00, 32'h0, 1'b0, 64'h0, 1'b1, 64'hA5,
                   2'b10, 32'h108, 1'b0, 64'h1, 1'b1, 1'b1};
        vt[2]  = '{2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 64'h0, 1'b1, 64'hA6,
                   2'b00, 32'h0, 1'b0, 64'h1, 1'b1, 1'b1};
        vt[3]  = '{2'b10, 32'h200, 1'b0, 2'b10, 32'h8000, 1'b1, 64'hDEAD_BEEF, 1'b1, 64'h0,
                   2'b10, 32'h200, 1'b0, 64'h0, 1'b1, 1'b1};
        vt[4]  = '{2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 64'hDEAD_BEEF, 1'b1, 64'hB0,
                   2'b10, 32'h8000, 1'b1, 64'h1, 1'b1, 1'b0};
        vt[5]  = '{2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 64'hDEAD_BEEF, 1'b1, 64'h0,
                   2'b00, 32'h0, 1'b0, 64'hDEAD_BEEF, 1'b1, 1'b1};
        vt[6]  = '{2'b00, 32'h0, 1'b0, 2'b10, 32'h9000, 1'b1, 64'h0, 1'b1, 64'h0,
                   2'b10, 32'h9000, 1'b1, 64'h0, 1'b1, 1'b1};
        vt[7]  = '{2'b10, 32'h300, 1'b0, 2'b00, 32'h0, 1'b0, 64'hCAFE, 1'b0, 64'h0,
                   2'b10, 32'h300, 1'b0, 64'hCAFE, 1'b1, 1'b0};
        vt[8]  = '{2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 64'hCAFE, 1'b0, 64'h0,
                   2'b10, 32'h300, 1'b0, 64'hCAFE, 1'b0, 1'b0};
        vt[9]  = vt[8];
        vt[10] = '{2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 64'hCAFE, 1'b1, 64'h0,
                   2'b10, 32'h300, 1'b0, 64'hCAFE, 1'b0, 1'b1};
        vt[11] = '{2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 64'h0, 1'b1, 64'h77,
                   2'b00, 32'h0, 1'b0, 64'h1, 1'b1, 1'b1};

        drive_m(0, 2'b00, '0, 1'b0, '0, '0);
        drive_m(1, 2'b00, '0, 1'b0, '0, '0);
        s_if.hready = 1'b1;
        s_if.hrdata = '0;
        model_reset();
        @(negedge HCLK);
        chk("reset_htrans", 64'(s_if.htrans), 64'h0);
        chk("reset_hready_m1", 64'(m1_if.hready), 64'h1);
        chk("reset_hready_m2", 64'(m2_if.hready), 64'h1);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive_m(0, vt[i].t1, vt[i].a1, vt[i].w1, 3'd3, 64'h1);
            drive_m(1, vt[i].t2, vt[i].a2, vt[i].w2, 3'd3, vt[i].wd2);
            s_if.hready = vt[i].rdy;
            s_if.hrdata = vt[i].rdata;
            @(negedge HCLK);
            model_eval();
`ifndef AHB_ARB_RR_EN
            chk($sformatf("tbl%0d_htrans", i), 64'(s_if.htrans), 64'(vt[i].x_trans));
            chk($sformatf("tbl%0d_haddr", i), 64'(s_if.haddr), 64'(vt[i].x_addr));
            chk($sformatf("tbl%0d_hwrite", i), 64'(s_if.hwrite), 64'(vt[i].x_write));
            chk($sformatf("tbl%0d_hwdata", i), s_if.hwdata, vt[i].x_wdata);
            chk($sformatf("tbl%0d_hready_m1", i), 64'(m1_if.hready), 64'(vt[i].x_hr1));
            chk($sformatf("tbl%0d_hready_m2", i), 64'(m2_if.hready), 64'(vt[i].x_hr2));
            chk($sformatf("tbl%0d_hrdata_m1", i), m1_if.hrdata, vt[i].rdata);
`endif
            check_model($sformatf("tbl%0d", i));
            tick();
        end

        // Reset pulse while M1's address phase is stalled by the slave.
        drive_m(0, 2'b10, 32'h400, 1'b0, 3'd2, 64'h0);
        drive_m(1, 2'b00, '0, 1'b0, '0, '0);
        s_if.hready = 1'b0;
        @(negedge HCLK);
        model_eval();
        check_model("rst_pre");
        tick();
        drive_m(0, 2'b10, 32'h408, 1'b1, 3'd2, 64'h1234);
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        chk("rst_htrans", 64'(s_if.htrans), 64'h0);
        chk("rst_haddr", 64'(s_if.haddr), 64'h0);
        chk("rst_hwrite", 64'(s_if.hwrite), 64'h0);
        chk("rst_hsize", 64'(s_if.hsize), 64'h0);
        chk("rst_hwdata", s_if.hwdata, 64'h0);
        chk("rst_hready_m1", 64'(m1_if.hready), 64'h1);
        chk("rst_hready_m2", 64'(m2_if.hready), 64'h1);
        @(posedge HCLK);
        #1;
        drive_m(0, 2'b00, '0, 1'b0, '0, '0);
        s_if.hready = 1'b1;
        #2;
        HRESETn = 1'b1;
        @(negedge HCLK);
        model_eval();
        chk("rel_hready_m1", 64'(m1_if.hready), 64'h1);
        chk("rel_hready_m2", 64'(m2_if.hready), 64'h1);
        chk("rel_htrans", 64'(s_if.htrans), 64'h0);
        check_model("rel");
        tick();

        // M1 streams back-to-back; M2 requests once.
        k = 0;
        for (int c = 0; c < 8; c++) begin
            drive_m(0, 2'b10, 32'h1000 + 32'(8 * k), 1'b0, 3'd3, 64'h0);
            if (c == 0) drive_m(1, 2'b10, 32'hA000, 1'b1, 3'd3, 64'h55);
            else drive_m(1, 2'b00, 32'h0, 1'b0, 3'd0, 64'h55);
            @(negedge HCLK);
            model_eval();
            check_model($sformatf("starve%0d", c));
`ifndef AHB_ARB_RR_EN
            chk($sformatf("starve%0d_haddr", c), 64'(s_if.haddr), 64'(32'h1000 + 32'(8 * c)));
            if (c > 0) chk($sformatf("starve%0d_hready_m2", c), 64'(m2_if.hready), 64'h0);
`else
            if (c == 0) chk("rr0_haddr", 64'(s_if.haddr), 64'h1000);
            if (c == 1) chk("rr1_haddr", 64'(s_if.haddr), 64'hA000);
            if (c == 2) chk("rr2_haddr", 64'(s_if.haddr), 64'h1008);
            if (c == 2) chk("rr2_hready_m2", 64'(m2_if.hready), 64'h1);
`endif
            if (m1_if.hready) k++;
            tick();
        end
        drive_m(0, 2'b00, '0, 1'b0, '0, '0);
        drive_m(1, 2'b00, '0, 1'b0, '0, 64'h55);
        @(negedge HCLK);
        model_eval();
        check_model("starve_end");
`ifndef AHB_ARB_RR_EN
        chk("starve_end_haddr", 64'(s_if.haddr), 64'hA000);
        chk("starve_end_hwrite", 64'(s_if.hwrite), 64'h1);
`endif
        tick();

        for (int c = 0; c < 3000; c++) begin
            drive_m(0, 2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFF8, 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 3)), {$urandom(), $urandom()});
            drive_m(1, 2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFF8, 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 3)), {$urandom(), $urandom()});
            s_if.hready = ($urandom_range(0, 3) != 0);
            s_if.hrdata = {$urandom(), $urandom()};
            @(negedge HCLK);
            model_eval();
            check_model("rnd");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
